// File: rtl/sram_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter in front of sram_controller.
// Holds the FSM state encoding and the master index constants.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_M0 = 2'd1,
        GRANT_M1 = 2'd2
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/wishbone_if.sv
// Classic Wishbone bundle; dat_o is master-to-slave, dat_i is slave-to-master.
// The master modport drives the cycle, the slave modport answers with ack/data.
interface wishbone_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [ADDR_WIDTH-1:0] adr;
    logic [SEL_WIDTH-1:0]  sel;
    logic [DATA_WIDTH-1:0] dat_o;
    logic [DATA_WIDTH-1:0] dat_i;
    logic                  ack;

    modport master (
        output cyc, stb, we, adr, sel, dat_o,
        input  dat_i, ack
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_o,
        output dat_i, ack
    );

endinterface

// File: rtl/wb_rr_pick.sv
// Chooses which requester wins the next IDLE evaluation.
// Round-robin favours the master not granted last; fixed mode always favours m0.
module wb_rr_pick
    import sram_arb_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       pick
);

    // Lone requester wins outright; contention resolved by mode and history.
    always_comb begin
        pick = M0;
        case (req)
            2'b10:   pick = M1;
            2'b11:   pick = ((ROUND_ROBIN != 0) && (last_grant == M0)) ? M1 : M0;
            default: pick = M0;
        endcase
    end

endmodule

// File: rtl/sram_wb_arbiter.sv
// Two-master Wishbone arbiter sharing one sram_controller port.
// A grant is held until the owner drops cyc, so locked sequences stay atomic.
module sram_wb_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int ROUND_ROBIN = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    wishbone_if.slave  m0_if,
    wishbone_if.slave  m1_if,
    wishbone_if.master s_if,
    output logic [1:0] grant_o,
    output logic       busy_o
);

    state_t     state;
    state_t     state_nxt;
    logic       last_grant;
    logic       pick;
    logic [1:0] req;

    assign req = {m1_if.cyc & m1_if.stb, m0_if.cyc & m0_if.stb};

    wb_rr_pick #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_pick (
        .req        (req),
        .last_grant (last_grant),
        .pick       (pick)
    );

    // State and arbitration history; last_grant starts at m1 so m0 wins first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            last_grant <= M1;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req != 2'b00) begin
                last_grant <= pick;
            end
        end
    end

    // Next state: grant from IDLE, release only when the owner drops cyc.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    state_nxt = (pick == M0) ? GRANT_M0 : GRANT_M1;
                end
            end
            GRANT_M0: if (!m0_if.cyc) state_nxt = IDLE;
            GRANT_M1: if (!m1_if.cyc) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    assign grant_o = {state == GRANT_M1, state == GRANT_M0};
    assign busy_o  = |grant_o;

    assign m0_if.dat_i = s_if.dat_i;
    assign m1_if.dat_i = s_if.dat_i;

    // Bus mux: owner's request goes downstream, ack returns only to the owner.
    always_comb begin
        s_if.cyc   = 1'b0;
        s_if.stb   = 1'b0;
        s_if.we    = 1'b0;
        s_if.adr   = {ADDR_WIDTH{1'b0}};
        s_if.sel   = {(DATA_WIDTH / 8){1'b0}};
        s_if.dat_o = {DATA_WIDTH{1'b0}};
        m0_if.ack  = 1'b0;
        m1_if.ack  = 1'b0;
        case (state)
            GRANT_M0: begin
                s_if.cyc   = m0_if.cyc;
                s_if.stb   = m0_if.stb;
                s_if.we    = m0_if.we;
                s_if.adr   = m0_if.adr;
                s_if.sel   = m0_if.sel;
                s_if.dat_o = m0_if.dat_o;
                m0_if.ack  = s_if.ack;
            end
            GRANT_M1: begin
                s_if.cyc   = m1_if.cyc;
                s_if.stb   = m1_if.stb;
                s_if.we    = m1_if.we;
                s_if.adr   = m1_if.adr;
                s_if.sel   = m1_if.sel;
                s_if.dat_o = m1_if.dat_o;
                m1_if.ack  = s_if.ack;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sram_wb_arbiter.sv
// Directed bench for sram_wb_arbiter: a round-robin instance on a small SRAM
// model and a fixed-priority instance on a plain single-wait-state acker.
module tb_sram_wb_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] grant;
    logic       busy;
    logic [1:0] fgrant;
    logic       fbusy;

    int passed = 0;
    int total  = 0;

    logic [31:0] rd;
    logic [31:0] mem [0:255];

    wishbone_if m0b ();
    wishbone_if m1b ();
    wishbone_if sb  ();
    wishbone_if f0b ();
    wishbone_if f1b ();
    wishbone_if fsb ();

    sram_wb_arbiter #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .ROUND_ROBIN (1)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .m0_if   (m0b),
        .m1_if   (m1b),
        .s_if    (sb),
        .grant_o (grant),
        .busy_o  (busy)
    );

    sram_wb_arbiter #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .ROUND_ROBIN (0)
    ) dut_fp (
        .clk_i   (clk),
        .rst_i   (rst),
        .m0_if   (f0b),
        .m1_if   (f1b),
        .s_if    (fsb),
        .grant_o (fgrant),
        .busy_o  (fbusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: one wait state, registered ack and read data, byte enables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb.ack   <= 1'b0;
            sb.dat_i <= 32'h0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | i;
        end else begin
            sb.ack <= 1'b0;
            if (sb.cyc && sb.stb && !sb.ack) begin
                sb.ack <= 1'b1;
                if (sb.we) begin
                    for (int b = 0; b < 4; b++)
                        if (sb.sel[b]) mem[sb.adr[9:2]][8*b +: 8] <= sb.dat_o[8*b +: 8];
                end else begin
                    sb.dat_i <= mem[sb.adr[9:2]];
                end
            end
        end
    end

    // Plain acker for the fixed-priority instance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsb.ack   <= 1'b0;
            fsb.dat_i <= 32'h0;
        end else begin
            fsb.ack <= fsb.cyc && fsb.stb && !fsb.ack;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input int who, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
        case (who)
            0: begin m0b.cyc = 1; m0b.stb = 1; m0b.we = we; m0b.adr = adr; m0b.dat_o = dat; m0b.sel = sel; end
            1: begin m1b.cyc = 1; m1b.stb = 1; m1b.we = we; m1b.adr = adr; m1b.dat_o = dat; m1b.sel = sel; end
            2: begin f0b.cyc = 1; f0b.stb = 1; f0b.we = we; f0b.adr = adr; f0b.dat_o = dat; f0b.sel = sel; end
            default: begin f1b.cyc = 1; f1b.stb = 1; f1b.we = we; f1b.adr = adr; f1b.dat_o = dat; f1b.sel = sel; end
        endcase
    endtask

    task automatic release_bus(input int who);
        case (who)
            0: begin m0b.cyc = 0; m0b.stb = 0; m0b.we = 0; m0b.adr = 0; m0b.dat_o = 0; m0b.sel = 0; end
            1: begin m1b.cyc = 0; m1b.stb = 0; m1b.we = 0; m1b.adr = 0; m1b.dat_o = 0; m1b.sel = 0; end
            2: begin f0b.cyc = 0; f0b.stb = 0; f0b.we = 0; f0b.adr = 0; f0b.dat_o = 0; f0b.sel = 0; end
            default: begin f1b.cyc = 0; f1b.stb = 0; f1b.we = 0; f1b.adr = 0; f1b.dat_o = 0; f1b.sel = 0; end
        endcase
    endtask

    // Waits (bounded) at falling edges for the master's ack; the other
    // master on the same arbiter must never see an ack meanwhile.
    task automatic wait_ack(input int who, output logic [31:0] data);
        logic got;
        logic other;
        got   = 1'b0;
        other = 1'b0;
        data  = 32'h0;
        for (int n = 0; n < 16 && !got; n++) begin
            @(negedge clk);
            case (who)
                0: begin other |= m1b.ack; if (m0b.ack) begin got = 1; data = m0b.dat_i; end end
                1: begin other |= m0b.ack; if (m1b.ack) begin got = 1; data = m1b.dat_i; end end
                2: begin other |= f1b.ack; if (f0b.ack) begin got = 1; data = f0b.dat_i; end end
                default: begin other |= f0b.ack; if (f1b.ack) begin got = 1; data = f1b.dat_i; end end
            endcase
        end
        chk($sformatf("ack_seen_m%0d", who), got, 1);
        chk($sformatf("stray_ack_m%0d", who), other, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        for (int w = 0; w < 4; w++) release_bus(w);
        #1 rst = 1'b1;
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 0);
        chk("rst_cyc", sb.cyc, 0);
        chk("rst_stb", sb.stb, 0);
        chk("rst_we", sb.we, 0);
        chk("rst_ack0", m0b.ack, 0);
        chk("rst_ack1", m1b.ack, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single read by m0 straight after reset
        drive(0, 0, 32'h10, 32'h0, 4'hF);
        @(posedge clk); #1;
        chk("rd_grant", grant, 2'b01);
        chk("rd_busy", busy, 1);
        chk("rd_adr", sb.adr, 32'h10);
        chk("rd_stb", sb.stb, 1);
        wait_ack(0, rd);
        chk("rd_data", rd, 32'hC0DE_0004);
        release_bus(0);
        @(posedge clk); #1;
        chk("rd_idle_grant", grant, 2'b00);
        chk("rd_idle_adr", sb.adr, 32'h0);

        // Contention under round-robin from a fresh reset
        do_reset();
        drive(0, 0, 32'h10, 32'h0, 4'hF);
        drive(1, 0, 32'h14, 32'h0, 4'hF);
        @(posedge clk); #1;
        chk("rr_first_m0", grant, 2'b01);
        wait_ack(0, rd);
        chk("rr_m0_data", rd, 32'hC0DE_0004);
        release_bus(0);
        @(posedge clk); #1;
        chk("rr_gap_idle", grant, 2'b00);
        chk("rr_gap_stb", sb.stb, 0);
        @(negedge clk);
        drive(0, 0, 32'h18, 32'h0, 4'hF);
        @(posedge clk); #1;
        chk("rr_then_m1", grant, 2'b10);
        chk("rr_m1_adr", sb.adr, 32'h14);
        wait_ack(1, rd);
        chk("rr_m1_data", rd, 32'hC0DE_0005);
        release_bus(1);
        @(posedge clk); #1;
        chk("rr_gap2_idle", grant, 2'b00);
        @(posedge clk); #1;
        chk("rr_m0_again", grant, 2'b01);
        wait_ack(0, rd);
        chk("rr_m0_data2", rd, 32'hC0DE_0006);
        release_bus(0);
        @(posedge clk); #1;

        // Locked m1 write burst while m0 waits
        @(negedge clk);
        drive(1, 1, 32'h100, 32'hA000_0100, 4'hF);
        @(posedge clk); #1;
        chk("lk_grant_m1", grant, 2'b10);
        @(negedge clk);
        drive(0, 0, 32'h100, 32'h0, 4'hF);
        for (int k = 0; k < 3; k++) begin
            wait_ack(1, rd);
            chk($sformatf("lk_hold_%0d", k), grant, 2'b10);
            if (k < 2) begin
                m1b.adr   = 32'h104 + 32'(4 * k);
                m1b.dat_o = 32'hA000_0104 + 32'(4 * k);
            end else begin
                release_bus(1);
            end
        end
        @(posedge clk); #1;
        chk("lk_idle", grant, 2'b00);
        @(posedge clk); #1;
        chk("lk_m0_granted", grant, 2'b01);
        wait_ack(0, rd);
        chk("lk_rd_100", rd, 32'hA000_0100);
        m0b.adr = 32'h108;
        wait_ack(0, rd);
        chk("lk_rd_108", rd, 32'hA000_0108);
        release_bus(0);
        @(posedge clk); #1;

        // Fixed priority: m0 keeps re-requesting, m1 waits throughout
        @(negedge clk);
        drive(2, 1, 32'h40, 32'h1111_1111, 4'hF);
        drive(3, 1, 32'h44, 32'h2222_2222, 4'hF);
        @(posedge clk); #1;
        chk("fp_first_m0", fgrant, 2'b01);
        wait_ack(2, rd);
        release_bus(2);
        @(posedge clk); #1;
        chk("fp_idle", fgrant, 2'b00);
        @(negedge clk);
        drive(2, 1, 32'h48, 32'h3333_3333, 4'hF);
        @(posedge clk); #1;
        chk("fp_m0_again", fgrant, 2'b01);
        wait_ack(2, rd);
        release_bus(2);
        @(posedge clk); #1;
        chk("fp_idle2", fgrant, 2'b00);
        @(posedge clk); #1;
        chk("fp_m1_last", fgrant, 2'b10);
        chk("fp_m1_adr", fsb.adr, 32'h44);
        wait_ack(3, rd);
        release_bus(3);
        @(posedge clk); #1;

        // Byte-lane write by m1, read back by m0
        @(negedge clk);
        drive(1, 1, 32'h200, 32'hDEAD_BEEF, 4'b0011);
        wait_ack(1, rd);
        release_bus(1);
        drive(0, 0, 32'h200, 32'h0, 4'hF);
        wait_ack(0, rd);
        chk("byte_merge", rd, 32'hC0DE_BEEF);
        release_bus(0);
        @(posedge clk); #1;

        // Asynchronous reset during an unacknowledged write
        @(negedge clk);
        drive(1, 1, 32'h300, 32'h5555_AAAA, 4'hF);
        @(posedge clk); #1;
        chk("mr_grant", grant, 2'b10);
        chk("mr_cyc", sb.cyc, 1);
        #2 rst = 1'b1;
        #1;
        chk("mr_cyc_now", sb.cyc, 0);
        chk("mr_stb_now", sb.stb, 0);
        chk("mr_we_now", sb.we, 0);
        chk("mr_grant_now", grant, 2'b00);
        chk("mr_busy_now", busy, 0);
        @(posedge clk); #1;
        chk("mr_no_ack1", m1b.ack, 0);
        chk("mr_no_ack0", m0b.ack, 0);
        @(negedge clk);
        release_bus(1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mr_after_grant", grant, 2'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
